// File: rtl/snitch_data_mem_bist_pkg.sv
// Shared types and constants for the TCDM March C- BIST initiator.
// Optional feature macro: SNITCH_DATA_MEM_BIST_CHECKERBOARD_EN (adds a checkerboard background pass).
package snitch_data_mem_bist_pkg;

  localparam int unsigned MaxDataWidth = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bist_state_e;

  typedef enum logic [2:0] {
    M0 = 3'd0,
    M1 = 3'd1,
    M2 = 3'd2,
    M3 = 3'd3,
    M4 = 3'd4,
    M5 = 3'd5
  } march_elem_e;

  // Per-element behaviour: direction, read/write presence and data polarity.
  typedef struct packed {
    logic up;
    logic rd;
    logic wr;
    logic rd_inv;
    logic wr_inv;
  } elem_cfg_t;

  // March C- element table.
  function automatic elem_cfg_t elem_cfg(input march_elem_e e);
    elem_cfg_t c;
    case (e)
      M0:      c = '{up: 1'b1, rd: 1'b0, wr: 1'b1, rd_inv: 1'b0, wr_inv: 1'b0};
      M1:      c = '{up: 1'b1, rd: 1'b1, wr: 1'b1, rd_inv: 1'b0, wr_inv: 1'b1};
      M2:      c = '{up: 1'b1, rd: 1'b1, wr: 1'b1, rd_inv: 1'b1, wr_inv: 1'b0};
      M3:      c = '{up: 1'b0, rd: 1'b1, wr: 1'b1, rd_inv: 1'b0, wr_inv: 1'b1};
      M4:      c = '{up: 1'b0, rd: 1'b1, wr: 1'b1, rd_inv: 1'b1, wr_inv: 1'b0};
      M5:      c = '{up: 1'b0, rd: 1'b1, wr: 1'b0, rd_inv: 1'b0, wr_inv: 1'b0};
      default: c = '0;
    endcase
    return c;
  endfunction

  // 0x55..55 checkerboard; callers truncate to the word width.
  function automatic logic [MaxDataWidth-1:0] checker_pattern();
    return {(MaxDataWidth / 2){2'b01}};
  endfunction

endpackage

// File: rtl/snitch_data_mem_bist_if.sv
// Bank request/response bundle between the BIST initiator and the TCDM banks.
interface snitch_data_mem_bist_if #(
  parameter int unsigned NumTotalBanks   = 32,
  parameter int unsigned AddrWidth       = 10,
  parameter int unsigned NarrowDataWidth = 64
);
  localparam int unsigned BeWidth = NarrowDataWidth / 8;

  logic [NumTotalBanks-1:0]                      mem_cs_o;
  logic [NumTotalBanks-1:0]                      mem_wen_o;
  logic [NumTotalBanks-1:0][AddrWidth-1:0]       mem_add_o;
  logic [NumTotalBanks-1:0][BeWidth-1:0]         mem_be_o;
  logic [NumTotalBanks-1:0][NarrowDataWidth-1:0] mem_wdata_o;
  logic [NumTotalBanks-1:0][NarrowDataWidth-1:0] mem_rdata_i;

  modport master (
    output mem_cs_o, mem_wen_o, mem_add_o, mem_be_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_cs_o, mem_wen_o, mem_add_o, mem_be_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/snitch_data_mem_bist_checker.sv
// Per-bank read-data comparator with sticky fail flags and first-fail address capture.
module snitch_data_mem_bist_checker #(
  parameter int unsigned NumTotalBanks   = 32,
  parameter int unsigned NarrowDataWidth = 64,
  parameter int unsigned AddrWidth       = 10
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      clear_i,
  input  logic                                      rd_valid_i,
  input  logic [AddrWidth-1:0]                      rd_addr_i,
  input  logic [NarrowDataWidth-1:0]                exp_data_i,
  input  logic [NumTotalBanks-1:0][NarrowDataWidth-1:0] rdata_i,
  output logic [NumTotalBanks-1:0]                  fail_bank_o,
  output logic [AddrWidth-1:0]                      fail_addr_o,
  output logic [NumTotalBanks-1:0]                  mismatch_c
);
  logic                       valid_q;
  logic [NarrowDataWidth-1:0] exp_q;
  logic [AddrWidth-1:0]       addr_q;

  // Compare each bank's returned word against the expectation of the previous read.
  always_comb begin
    mismatch_c = '0;
    for (int b = 0; b < int'(NumTotalBanks); b++) begin
      mismatch_c[b] = valid_q && (rdata_i[b] != exp_q);
    end
  end

  // Capture read expectation; accumulate flags, keep only the first failing address.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= 1'b0;
      exp_q       <= '0;
      addr_q      <= '0;
      fail_bank_o <= '0;
      fail_addr_o <= '0;
    end else begin
      valid_q <= rd_valid_i;
      exp_q   <= exp_data_i;
      addr_q  <= rd_addr_i;
      if (clear_i) begin
        fail_bank_o <= '0;
        fail_addr_o <= '0;
      end else if (|mismatch_c) begin
        fail_bank_o <= fail_bank_o | mismatch_c;
        if (!(|fail_bank_o)) fail_addr_o <= addr_q;
      end
    end
  end
endmodule

// File: rtl/snitch_data_mem_bist.sv
// March C- BIST initiator driving all TCDM banks in lockstep.
// Optional macro SNITCH_DATA_MEM_BIST_CHECKERBOARD_EN: repeat the march with a 0x55..55 background.
module snitch_data_mem_bist
  import snitch_data_mem_bist_pkg::*;
#(
  parameter int unsigned TCDMDepth       = 1024,
  parameter int unsigned NarrowDataWidth = 64,
  parameter int unsigned NumTotalBanks   = 32,
  localparam int unsigned AddrWidth      = $clog2(TCDMDepth)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic [NumTotalBanks-1:0] fail_bank_o,
  output logic [AddrWidth-1:0]     fail_addr_o,
  snitch_data_mem_bist_if.master   mem
);
  localparam int unsigned BeWidth = NarrowDataWidth / 8;
  localparam logic [AddrWidth-1:0] AddrMax = AddrWidth'(TCDMDepth - 1);
  localparam logic [NarrowDataWidth-1:0] CheckerPat = NarrowDataWidth'(checker_pattern());

  bist_state_e                state_q, state_d;
  march_elem_e                elem_q, elem_d;
  logic [AddrWidth-1:0]       addr_q, addr_d;
  logic                       phase_q, phase_d;
  logic                       bg_q, bg_d;
  elem_cfg_t                  cur_cfg, nxt_cfg, req_cfg;
  logic                       run_d, wr_d;
  logic [NarrowDataWidth-1:0] bg_pat, wdata_d, rexp_d;

  logic                       cs_q, wen_q, busy_q, done_q, pass_q;
  logic [AddrWidth-1:0]       add_q;
  logic [NarrowDataWidth-1:0] wdata_q, rexp_q;
  logic                       start_acc_c;
  logic [NumTotalBanks-1:0]   mismatch_c;

  assign start_acc_c = (state_q == IDLE) && start_i;

  // Next-state sequencing of element/address/phase and the request for the next cycle.
  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    bg_d    = bg_q;
    cur_cfg = elem_cfg(elem_q);
    nxt_cfg = elem_cfg(march_elem_e'(elem_q + 3'd1));
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          elem_d  = M0;
          addr_d  = '0;
          phase_d = 1'b0;
          bg_d    = 1'b0;
        end
      end
      RUN: begin
        if (cur_cfg.rd && cur_cfg.wr && !phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (addr_q == (cur_cfg.up ? AddrMax : '0)) begin
            if (elem_q == M5) begin
`ifdef SNITCH_DATA_MEM_BIST_CHECKERBOARD_EN
              if (!bg_q) begin
                bg_d   = 1'b1;
                elem_d = M0;
                addr_d = '0;
              end else begin
                state_d = DRAIN;
              end
`else
              state_d = DRAIN;
`endif
            end else begin
              elem_d = march_elem_e'(elem_q + 3'd1);
              addr_d = nxt_cfg.up ? '0 : AddrMax;
            end
          end else begin
            addr_d = cur_cfg.up ? addr_q + AddrWidth'(1) : addr_q - AddrWidth'(1);
          end
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_cfg = elem_cfg(elem_d);
    run_d   = (state_d == RUN);
    wr_d    = run_d && req_cfg.wr && (phase_d || !req_cfg.rd);
    bg_pat  = bg_d ? CheckerPat : '0;
    wdata_d = wr_d ? (bg_pat ^ {NarrowDataWidth{req_cfg.wr_inv}}) : '0;
    rexp_d  = bg_pat ^ {NarrowDataWidth{req_cfg.rd_inv}};
  end

  // State register and registered bank/status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      elem_q  <= M0;
      addr_q  <= '0;
      phase_q <= 1'b0;
      bg_q    <= 1'b0;
      cs_q    <= 1'b0;
      wen_q   <= 1'b0;
      add_q   <= '0;
      wdata_q <= '0;
      rexp_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
      bg_q    <= bg_d;
      cs_q    <= run_d;
      wen_q   <= wr_d;
      add_q   <= run_d ? addr_d : '0;
      wdata_q <= wdata_d;
      rexp_q  <= rexp_d;
      busy_q  <= (state_d == RUN) || (state_d == DRAIN);
      done_q  <= (state_d == DONE);
      if (start_acc_c) pass_q <= 1'b0;
      else if (state_q == DRAIN) pass_q <= ~|(fail_bank_o | mismatch_c);
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign mem.mem_cs_o    = {NumTotalBanks{cs_q}};
  assign mem.mem_wen_o   = {NumTotalBanks{wen_q}};
  assign mem.mem_add_o   = {NumTotalBanks{add_q}};
  assign mem.mem_be_o    = {(NumTotalBanks * BeWidth){cs_q}};
  assign mem.mem_wdata_o = {NumTotalBanks{wdata_q}};

  snitch_data_mem_bist_checker #(
    .NumTotalBanks  (NumTotalBanks),
    .NarrowDataWidth(NarrowDataWidth),
    .AddrWidth      (AddrWidth)
  ) i_checker (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (start_acc_c),
    .rd_valid_i (cs_q && !wen_q),
    .rd_addr_i  (add_q),
    .exp_data_i (rexp_q),
    .rdata_i    (mem.mem_rdata_i),
    .fail_bank_o(fail_bank_o),
    .fail_addr_o(fail_addr_o),
    .mismatch_c (mismatch_c)
  );
endmodule

// File: tb/tb_snitch_data_mem_bist.sv
// Directed bench for the March C- BIST with a fault-injecting bank model.
module tb_snitch_data_mem_bist;
  localparam int unsigned Depth = 16;
  localparam int unsigned Banks = 4;
  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 4;
  localparam int unsigned BeW   = DW / 8;

`ifdef SNITCH_DATA_MEM_BIST_CHECKERBOARD_EN
  localparam int ExpDone = 322;
`else
  localparam int ExpDone = 162;
`endif

  logic clk = 1'b0;
  logic rst, start;
  logic busy, done, pass;
  logic [Banks-1:0] fail_bank;
  logic [AW-1:0]    fail_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int fault_mode = 0;

  logic [DW-1:0] mem [Banks][Depth];

  // cycle-1/2 snapshots taken by run_bist
  logic            s_busy1, s_pass1;
  logic [Banks-1:0] s_cs1, s_wen1, s_fail1;
  logic [Banks*BeW-1:0] s_be1;
  logic [Banks*AW-1:0]  s_add1, s_add2;
  logic [Banks*DW-1:0]  s_wdata1;

  snitch_data_mem_bist_if #(.NumTotalBanks(Banks), .AddrWidth(AW), .NarrowDataWidth(DW)) mem_if ();

  snitch_data_mem_bist #(.TCDMDepth(Depth), .NarrowDataWidth(DW), .NumTotalBanks(Banks)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done), .pass_o(pass),
    .fail_bank_o(fail_bank), .fail_addr_o(fail_addr), .mem(mem_if)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] faulty(input int b, input int a, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    case (fault_mode)
      1: if (b == 2 && a == 5) r[0] = 1'b1;
      2: begin
        if (b == 1 && a == 9) r[0] = 1'b1;
        if (b == 3 && a == 3) r[0] = 1'b0;
      end
      3: if (b == 0) r[1] = r[0];
      default: ;
    endcase
    return r;
  endfunction

  // Ideal 1-cycle-latency banks with read-path fault injection.
  always @(posedge clk) begin
    for (int b = 0; b < int'(Banks); b++) begin
      if (rst) begin
        for (int a = 0; a < int'(Depth); a++) mem[b][a] <= 64'hDEAD_BEEF_CAFE_F00D;
      end else if (mem_if.mem_cs_o[b]) begin
        if (mem_if.mem_wen_o[b]) begin
          for (int k = 0; k < int'(BeW); k++)
            if (mem_if.mem_be_o[b][k])
              mem[b][mem_if.mem_add_o[b]][8*k +: 8] <= mem_if.mem_wdata_o[b][8*k +: 8];
        end else begin
          mem_if.mem_rdata_i[b] <= faulty(b, int'(mem_if.mem_add_o[b]), mem[b][mem_if.mem_add_o[b]]);
        end
      end
    end
  end

  // Start a run in cycle 0, optionally re-pulse start, return done cycle (or timeout count).
  task automatic run_bist(input int repulse, output int cyc);
    @(posedge clk); #1 start = 1'b1; cyc = 0;
    @(posedge clk); #1 start = 1'b0; cyc = 1;
    s_busy1 = busy; s_pass1 = pass; s_cs1 = mem_if.mem_cs_o; s_wen1 = mem_if.mem_wen_o;
    s_fail1 = fail_bank; s_be1 = mem_if.mem_be_o; s_add1 = mem_if.mem_add_o; s_wdata1 = mem_if.mem_wdata_o;
    @(posedge clk); #1 cyc = 2;
    s_add2 = mem_if.mem_add_o;
    while (done !== 1'b1 && cyc < 1000) begin
      start = (cyc == repulse);
      @(posedge clk); #1 cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
    n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %0b expected 0", pass); end
    n_checks++; if (fail_bank !== 4'b0 || fail_addr !== 4'd0) begin
      n_fail++; $display("FAIL reset_flags: got bank %b addr %0d expected 0 0", fail_bank, fail_addr); end
    n_checks++; if (mem_if.mem_cs_o !== '0 || mem_if.mem_wen_o !== '0 || mem_if.mem_be_o !== '0) begin
      n_fail++; $display("FAIL reset_ctrl: got cs %b wen %b be %h expected 0", mem_if.mem_cs_o, mem_if.mem_wen_o, mem_if.mem_be_o); end
    n_checks++; if (mem_if.mem_add_o !== '0 || mem_if.mem_wdata_o !== '0) begin
      n_fail++; $display("FAIL reset_bus: got add %h wdata %h expected 0", mem_if.mem_add_o, mem_if.mem_wdata_o); end
    rst = 1'b0;
  endtask

  task automatic test_pass();
    int cyc;
    fault_mode = 0;
    run_bist(-1, cyc);
    n_checks++; if (s_busy1 !== 1'b1 || s_cs1 !== 4'hF || s_wen1 !== 4'hF) begin
      n_fail++; $display("FAIL first_req: got busy %b cs %b wen %b expected 1 1111 1111", s_busy1, s_cs1, s_wen1); end
    n_checks++; if (s_be1 !== 32'hFFFF_FFFF || s_add1 !== 16'h0000 || s_wdata1 !== '0) begin
      n_fail++; $display("FAIL first_bus: got be %h add %h wdata %h expected ffffffff 0000 0", s_be1, s_add1, s_wdata1); end
    n_checks++; if (s_add2 !== 16'h1111) begin
      n_fail++; $display("FAIL second_addr: got %h expected 1111", s_add2); end
    n_checks++; if (cyc !== ExpDone) begin n_fail++; $display("FAIL pass_done_cycle: got %0d expected %0d", cyc, ExpDone); end
    n_checks++; if (pass !== 1'b1 || fail_bank !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL pass_result: got pass %b bank %b busy %b expected 1 0000 0", pass, fail_bank, busy); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0 || pass !== 1'b1) begin
      n_fail++; $display("FAIL done_pulse: got done %b pass %b expected 0 1", done, pass); end
  endtask

  task automatic test_stuck_at1();
    int cyc;
    fault_mode = 1;
    run_bist(-1, cyc);
    n_checks++; if (s_pass1 !== 1'b0) begin n_fail++; $display("FAIL start_clears_pass: got %b expected 0", s_pass1); end
    n_checks++; if (cyc !== ExpDone) begin n_fail++; $display("FAIL sa1_done_cycle: got %0d expected %0d", cyc, ExpDone); end
    n_checks++; if (fail_bank !== 4'b0100 || fail_addr !== 4'd5 || pass !== 1'b0) begin
      n_fail++; $display("FAIL sa1_result: got bank %b addr %0d pass %b expected 0100 5 0", fail_bank, fail_addr, pass); end
  endtask

  task automatic test_two_faults();
    int cyc;
    fault_mode = 2;
    run_bist(-1, cyc);
    n_checks++; if (s_fail1 !== 4'b0000) begin n_fail++; $display("FAIL start_clears_flags: got %b expected 0000", s_fail1); end
    n_checks++; if (fail_bank !== 4'b1010 || fail_addr !== 4'd9 || pass !== 1'b0) begin
      n_fail++; $display("FAIL two_faults: got bank %b addr %0d pass %b expected 1010 9 0", fail_bank, fail_addr, pass); end
  endtask

  task automatic test_start_ignored();
    int cyc;
    fault_mode = 0;
    run_bist(50, cyc);
    n_checks++; if (cyc !== ExpDone || pass !== 1'b1) begin
      n_fail++; $display("FAIL restart_ignored: got cycle %0d pass %b expected %0d 1", cyc, pass, ExpDone); end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    int n_done;
    fault_mode = 1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; cyc = 1;
    while (cyc < 80) begin @(posedge clk); #1 cyc++; end
    n_checks++; if (fail_bank !== 4'b0100 || busy !== 1'b1) begin
      n_fail++; $display("FAIL pre_abort: got bank %b busy %b expected 0100 1", fail_bank, busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0 || mem_if.mem_cs_o !== 4'b0000 || fail_bank !== 4'b0000 || pass !== 1'b0) begin
      n_fail++; $display("FAIL abort: got busy %b cs %b bank %b pass %b expected 0 0000 0000 0", busy, mem_if.mem_cs_o, fail_bank, pass); end
    rst = 1'b0;
    n_done = 0;
    repeat (200) begin @(posedge clk); #1; if (done === 1'b1) n_done++; end
    n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d done pulses expected 0", n_done); end
  endtask

  task automatic test_checkerboard();
    int cyc;
    fault_mode = 3;
    run_bist(-1, cyc);
    n_checks++; if (cyc !== ExpDone) begin n_fail++; $display("FAIL cb_done_cycle: got %0d expected %0d", cyc, ExpDone); end
`ifdef SNITCH_DATA_MEM_BIST_CHECKERBOARD_EN
    n_checks++; if (fail_bank !== 4'b0001 || fail_addr !== 4'd0 || pass !== 1'b0) begin
      n_fail++; $display("FAIL cb_result: got bank %b addr %0d pass %b expected 0001 0 0", fail_bank, fail_addr, pass); end
`else
    n_checks++; if (fail_bank !== 4'b0000 || pass !== 1'b1) begin
      n_fail++; $display("FAIL cb_result: got bank %b pass %b expected 0000 1", fail_bank, pass); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_pass();
    test_stuck_at1();
    test_two_faults();
    test_start_ignored();
    test_reset_mid_run();
    test_checkerboard();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
